// File: rtl/calc_cmd_pkg.sv
// Shared constants, state type and opcode decode for the calculator command driver.
package calc_cmd_pkg;

  localparam logic [7:0] CMD_PUSH     = 8'h50;
  localparam logic [7:0] CMD_APPEND   = 8'h41;
  localparam logic [7:0] CMD_OP       = 8'h4F;
  localparam logic [7:0] CMD_RESET    = 8'h52;
  localparam logic [7:0] CMD_QUERY    = 8'h3F;

  localparam logic [7:0] RESP_UNKNOWN = 8'hEE;

  localparam int unsigned RESP_LEN = 6;
  localparam int unsigned LEN_W    = $clog2(RESP_LEN + 1);

  // Calculator button encodings
  localparam logic [3:0] BTN_NONE    = 4'b0000;
  localparam logic [3:0] BTN_READ_HI = 4'b0001;
  localparam logic [3:0] BTN_PUSH    = 4'b0010;
  localparam logic [3:0] BTN_APPEND  = 4'b0100;
  localparam logic [3:0] BTN_OP      = 4'b1000;
  localparam logic [3:0] BTN_RESET   = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ARG,
    ST_PULSE,
    ST_SETTLE,
    ST_READ_HI,
    ST_READ_LO,
    ST_SEND,
    ST_SEND_ERR
  } state_t;

  // Button pattern for the commands that carry an argument byte
  function automatic logic [3:0] cmd_btn(input logic [7:0] op);
    logic [3:0] b;
    b = BTN_NONE;
    case (op)
      CMD_PUSH:   b = BTN_PUSH;
      CMD_APPEND: b = BTN_APPEND;
      CMD_OP:     b = BTN_OP;
      default:    b = BTN_NONE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/calc_resp_serializer.sv
// Loads up to RESP_LEN bytes in parallel (first byte in the MSBs) and emits
// them one per handshake over valid/ready; o_done marks the final handshake.
module calc_resp_serializer
  import calc_cmd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [RESP_LEN*8-1:0] i_bytes,
  input  logic [LEN_W-1:0]      i_len,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_done
);

  logic [RESP_LEN*8-1:0] r_shift;
  logic [LEN_W-1:0]      r_left;
  logic                  r_valid;
  logic [7:0]            r_data;
  logic                  w_hs;
  logic                  w_last;

  assign w_hs       = r_valid & i_tx_ready;
  assign w_last     = (r_left == LEN_W'(1));
  assign o_done     = w_hs & w_last;
  assign o_tx_data  = r_data;
  assign o_tx_valid = r_valid;

  // Present one byte at a time; advance only on a handshake so data holds under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_data  <= i_bytes[RESP_LEN*8-1 -: 8];
      r_shift <= {i_bytes[RESP_LEN*8-9:0], 8'h00};
      r_left  <= i_len;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_left  <= '0;
      end else begin
        r_data  <= r_shift[RESP_LEN*8-1 -: 8];
        r_shift <= {r_shift[RESP_LEN*8-9:0], 8'h00};
        r_left  <= r_left - LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// Byte-stream front end for the RPN calculator: turns opcode/arg bytes into a
// single button pulse, waits for the calculator to settle, reads back the top
// of stack and status, and returns a 6-byte response (0xEE for unknown bytes).
module calc_cmd_driver
  import calc_cmd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] calc_sw,
  output logic [3:0] calc_btn,
  input  logic [15:0] calc_top,
  input  logic       calc_error,
  input  logic       calc_empty,
  input  logic [6:0] calc_stack_size
);

  localparam int unsigned    CW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  SETTLE_LOAD = CW'(SETTLE_CYCLES);

  state_t                r_state;
  logic                  r_rx_ready;
  logic [7:0]            r_sw;
  logic [3:0]            r_btn;
  logic [3:0]            r_btn_code;
  logic [CW-1:0]         r_cnt;
  logic                  r_phase;
  logic [15:0]           r_top_hi;

  logic                  w_rx_hs;
  logic                  w_unknown;
  logic                  w_load;
  logic [RESP_LEN*8-1:0] w_bytes;
  logic [LEN_W-1:0]      w_len;
  logic                  w_done;

  assign rx_ready = r_rx_ready;
  assign calc_sw  = r_sw;
  assign calc_btn = r_btn;
  assign w_rx_hs  = rx_valid & r_rx_ready;

  // Classify the incoming opcode and build the serializer load for either response kind
  always_comb begin
    w_unknown = 1'b1;
    case (rx_data)
      CMD_PUSH, CMD_APPEND, CMD_OP, CMD_RESET, CMD_QUERY: w_unknown = 1'b0;
      default:                                            w_unknown = 1'b1;
    endcase
    w_load  = ((r_state == ST_READ_LO) && r_phase) ||
              ((r_state == ST_IDLE) && w_rx_hs && w_unknown);
    w_len   = (r_state == ST_READ_LO) ? LEN_W'(RESP_LEN) : LEN_W'(1);
    w_bytes = (r_state == ST_READ_LO) ?
              {calc_error, calc_empty, 6'b0, 1'b0, calc_stack_size, r_top_hi, calc_top} :
              {RESP_UNKNOWN, {(RESP_LEN-1)*8{1'b0}}};
  end

  // Command sequencer: accept, pulse, settle, two-phase readback, then wait for the response to drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rx_ready <= 1'b0;
      r_sw       <= '0;
      r_btn      <= '0;
      r_btn_code <= '0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_top_hi   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_hs) begin
            case (rx_data)
              CMD_PUSH, CMD_APPEND, CMD_OP: begin
                r_btn_code <= cmd_btn(rx_data);
                r_state    <= ST_GET_ARG;
              end
              CMD_RESET: begin
                r_btn      <= BTN_RESET;
                r_sw       <= '0;
                r_rx_ready <= 1'b0;
                r_state    <= ST_PULSE;
              end
              CMD_QUERY: begin
                r_btn      <= BTN_READ_HI;
                r_sw       <= '0;
                r_phase    <= 1'b0;
                r_rx_ready <= 1'b0;
                r_state    <= ST_READ_HI;
              end
              default: begin
                r_rx_ready <= 1'b0;
                r_state    <= ST_SEND_ERR;
              end
            endcase
          end
        end
        ST_GET_ARG: begin
          if (w_rx_hs) begin
            r_sw       <= rx_data;
            r_btn      <= r_btn_code;
            r_rx_ready <= 1'b0;
            r_state    <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          r_btn   <= BTN_NONE;
          r_cnt   <= SETTLE_LOAD;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Leave on the last settle cycle so the high-half select is registered for READ_HI
          if (r_cnt <= CW'(1)) begin
            r_cnt   <= '0;
            r_btn   <= BTN_READ_HI;
            r_sw    <= '0;
            r_phase <= 1'b0;
            r_state <= ST_READ_HI;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_READ_HI: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_top_hi <= calc_top;
            r_btn    <= BTN_NONE;
            r_phase  <= 1'b0;
            r_state  <= ST_READ_LO;
          end
        end
        ST_READ_LO: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND, ST_SEND_ERR: begin
          if (w_done) begin
            r_rx_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  calc_resp_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_bytes    (w_bytes),
    .i_len      (w_len),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_done     (w_done)
  );

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Bench for calc_cmd_driver: a behavioural RPN calculator stub answers the
// button pulses, and a command-level stack model predicts every response.
module tb_calc_cmd_driver;

  localparam int unsigned S   = 12;
  localparam int          LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  calc_sw;
  logic [3:0]  calc_btn;
  logic [15:0] calc_top;
  logic        calc_error;
  logic        calc_empty;
  logic [6:0]  calc_stack_size;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // calculator stub state
  logic [31:0] c_stk[$];
  bit          c_err = 1'b0;
  int          c_busy = 0;
  logic [31:0] c_top = '0;
  int          c_size = 0;
  logic [3:0]  prev_btn = '0;
  int          pulses = 0;
  int          pulse_cyc = 0;
  int          hi_cycles = 0;
  int          btn_bad = 0;

  // reference model state
  logic [31:0] m_stk[$];
  bit          m_err = 1'b0;
  logic [47:0] exp_resp;
  int          exp_len;
  int          exp_pulses;

  // per-command observations
  logic [7:0]  got[$];
  logic [47:0] got_resp;
  int          first_valid;
  int          acc_cyc;
  int          stab_bad;
  bit          tmo;

  calc_cmd_driver #(.SETTLE_CYCLES(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .calc_sw         (calc_sw),
    .calc_btn        (calc_btn),
    .calc_top        (calc_top),
    .calc_error      (calc_error),
    .calc_empty      (calc_empty),
    .calc_stack_size (calc_stack_size)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Calculator outputs read as garbage while it is still busy after a pulse
  assign calc_top        = (c_busy != 0) ? 16'hBAD0 :
                           ((calc_btn == 4'b0001) ? c_top[31:16] : c_top[15:0]);
  assign calc_error      = (c_busy != 0) ? 1'b1 : c_err;
  assign calc_empty      = (c_busy != 0) ? 1'b0 : (c_size == 0);
  assign calc_stack_size = (c_busy != 0) ? 7'h55 : 7'(c_size);

  // RPN stack semantics: sel=1 updates the reference model, sel=0 the stub
  task automatic stk_apply(input bit sel, input logic [3:0] b, input logic [7:0] s);
    logic [31:0] q[$];
    bit e;
    logic [31:0] x, y, r;
    if (sel) begin q = m_stk; e = m_err; end
    else begin q = c_stk; e = c_err; end
    case (b)
      4'b1001: begin q.delete(); e = 1'b0; end
      4'b0010: begin q.push_back({24'h0, s}); e = 1'b0; end
      4'b0100: begin
        if (q.size() == 0) q.push_back({24'h0, s});
        else begin x = q.pop_back(); q.push_back({x[23:0], s}); end
        e = 1'b0;
      end
      4'b1000: begin
        if (s == 8'd5) begin
          if (q.size() == 0) e = 1'b1;
          else begin x = q.pop_back(); e = 1'b0; end
        end else if (s > 8'd5 || q.size() < 2) begin
          e = 1'b1;
        end else begin
          y = q.pop_back();
          x = q.pop_back();
          if ((s == 8'd3 || s == 8'd4) && y == 0) begin
            q.push_back(x); q.push_back(y); e = 1'b1;
          end else begin
            case (s)
              8'd0: r = x + y;
              8'd1: r = x - y;
              8'd2: r = x * y;
              8'd3: r = x / y;
              default: r = x % y;
            endcase
            q.push_back(r);
            e = 1'b0;
          end
        end
      end
      default: ;
    endcase
    if (sel) begin m_stk = q; m_err = e; end
    else begin c_stk = q; c_err = e; end
  endtask

  // Stub: reacts to each cycle's button pattern and watches pulse discipline
  initial forever begin
    @(negedge clk);
    if (c_busy > 0) c_busy--;
    if (calc_btn != 4'b0000 && calc_btn != 4'b0001) begin
      if (prev_btn != 4'b0000) btn_bad++;
      stk_apply(1'b0, calc_btn, calc_sw);
      c_busy = LAT;
      pulses++;
      pulse_cyc = cyc;
    end
    if (calc_btn == 4'b0001) begin
      hi_cycles++;
      if (calc_sw != 8'h00) btn_bad++;
      if (prev_btn != 4'b0000 && prev_btn != 4'b0001) btn_bad++;
    end
    prev_btn = calc_btn;
    c_top  = (c_stk.size() != 0) ? c_stk[c_stk.size()-1] : 32'h0;
    c_size = c_stk.size();
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", n_err);
    $fatal(1);
  end

  task automatic model_cmd(input logic [7:0] op, input logic [7:0] arg);
    logic [3:0] b;
    logic [31:0] t;
    exp_len = 6;
    case (op)
      8'h50: b = 4'b0010;
      8'h41: b = 4'b0100;
      8'h4F: b = 4'b1000;
      8'h52: b = 4'b1001;
      8'h3F: b = 4'b0000;
      default: begin b = 4'b0000; exp_len = 1; end
    endcase
    exp_pulses = (b != 4'b0000) ? 1 : 0;
    if (b != 4'b0000) stk_apply(1'b1, b, (op == 8'h52) ? 8'h00 : arg);
    if (exp_len == 1) exp_resp = {8'hEE, 40'h0};
    else begin
      t = (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : 32'h0;
      exp_resp = {m_err, (m_stk.size() == 0), 6'b0, 1'b0, 7'(m_stk.size()), t};
    end
  endtask

  task automatic wait_rx_ready();
    int n;
    n = 0;
    while (!rx_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!rx_ready) tmo = 1'b1;
  endtask

  // Drives one command and collects its response under the given tx_ready pattern
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] arg, input bit has_arg, input int mode);
    int n;
    bit pv, pr, rdy;
    logic [7:0] pd;
    got.delete(); first_valid = -1; stab_bad = 0; tmo = 1'b0;
    pulses = 0; hi_cycles = 0;
    rx_valid = 1'b1; rx_data = op;
    wait_rx_ready();
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (has_arg) begin
      rx_data = arg;
      wait_rx_ready();
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; rx_data = '0;
    n = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    while (got.size() < exp_len && n < 400) begin
      if (pv && !pr && (!tx_valid || tx_data !== pd)) stab_bad++;
      if (tx_valid && first_valid < 0) first_valid = cyc;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (((cyc / 3) % 2) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      pv = tx_valid; pr = rdy; pd = tx_data;
      if (tx_valid && rdy) got.push_back(tx_data);
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b0;
    if (n >= 400) tmo = 1'b1;
    got_resp = '0;
    for (int i = 0; i < got.size() && i < 6; i++) got_resp[47-8*i -: 8] = got[i];
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [7:0] arg, input int mode);
    model_cmd(op, arg);
    run_cmd(op, arg, (op == 8'h50 || op == 8'h41 || op == 8'h4F), mode);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready got=%b want=0", rx_ready); end
    n_chk++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    n_chk++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    n_chk++; if (calc_btn !== 4'h0) begin n_err++; $display("FAIL reset_btn got=%b want=0000", calc_btn); end
    n_chk++; if (calc_sw !== 8'h00) begin n_err++; $display("FAIL reset_sw got=%h want=00", calc_sw); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_rx_ready got=%b want=1", rx_ready); end
  endtask

  task automatic test_arith();
    logic [7:0] ops[3];
    logic [7:0] args[3];
    ops = '{8'h50, 8'h50, 8'h4F};
    args = '{8'h12, 8'h34, 8'h00};
    for (int i = 0; i < 3; i++) begin
      do_cmd(ops[i], args[i], 0);
      n_chk++; if (tmo || got_resp !== exp_resp) begin n_err++; $display("FAIL arith_resp[%0d] got=%h want=%h tmo=%0d", i, got_resp, exp_resp, tmo); end
      n_chk++; if (pulses !== 1) begin n_err++; $display("FAIL arith_pulses[%0d] got=%0d want=1", i, pulses); end
      n_chk++; if (pulse_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL arith_pulse_lat[%0d] got=%0d want=1", i, pulse_cyc - acc_cyc); end
      n_chk++; if (first_valid - pulse_cyc !== int'(S) + 5) begin n_err++; $display("FAIL arith_tx_lat[%0d] got=%0d want=%0d", i, first_valid - pulse_cyc, int'(S) + 5); end
      n_chk++; if (hi_cycles !== 2) begin n_err++; $display("FAIL arith_read_hi_len[%0d] got=%0d want=2", i, hi_cycles); end
    end
    n_chk++; if (got_resp !== 48'h000100000046) begin n_err++; $display("FAIL arith_final got=%h want=000100000046", got_resp); end
  endtask

  task automatic test_error();
    do_cmd(8'h52, 8'h00, 0);
    n_chk++; if (got_resp !== exp_resp || pulses !== 1) begin n_err++; $display("FAIL calc_reset got=%h/%0d want=%h/1", got_resp, pulses, exp_resp); end
    do_cmd(8'h4F, 8'h05, 0);
    n_chk++; if (got_resp[47:32] !== 16'hC000) begin n_err++; $display("FAIL pop_empty_status got=%h want=c000", got_resp[47:32]); end
    n_chk++; if (got_resp !== exp_resp) begin n_err++; $display("FAIL pop_empty_model got=%h want=%h", got_resp, exp_resp); end
  endtask

  task automatic test_divmod();
    logic [7:0] ops[7];
    logic [7:0] args[7];
    ops = '{8'h50, 8'h50, 8'h4F, 8'h52, 8'h50, 8'h50, 8'h4F};
    args = '{8'h64, 8'h07, 8'h03, 8'h00, 8'h64, 8'h07, 8'h04};
    for (int i = 0; i < 7; i++) begin
      do_cmd(ops[i], args[i], 0);
      n_chk++; if (tmo || got_resp !== exp_resp) begin n_err++; $display("FAIL divmod_resp[%0d] got=%h want=%h", i, got_resp, exp_resp); end
      if (i == 2) begin
        n_chk++; if (got_resp[31:0] !== 32'h0000000E) begin n_err++; $display("FAIL div_top got=%h want=0000000e", got_resp[31:0]); end
      end
    end
    n_chk++; if (got_resp[31:0] !== 32'h00000002 || got_resp[47:40] !== 8'h00) begin n_err++; $display("FAIL mod_top got=%h want=00..00000002", got_resp); end
  endtask

  task automatic test_append();
    logic [7:0] ops[6];
    logic [7:0] args[6];
    ops = '{8'h52, 8'h50, 8'h41, 8'h41, 8'h41, 8'h41};
    args = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 6; i++) begin
      do_cmd(ops[i], args[i], 1);
      n_chk++; if (tmo || got_resp !== exp_resp || stab_bad != 0) begin n_err++; $display("FAIL append_resp[%0d] got=%h want=%h unstable=%0d", i, got_resp, exp_resp, stab_bad); end
    end
    n_chk++; if (got_resp[39:0] !== 40'h013456789A) begin n_err++; $display("FAIL append_top got=%h want=013456789a", got_resp[39:0]); end
  endtask

  task automatic test_unknown();
    do_cmd(8'h5A, 8'h00, 0);
    n_chk++; if (tmo || got.size() !== 1 || got[0] !== 8'hEE) begin n_err++; $display("FAIL unknown_resp got=%h n=%0d want=ee n=1", got_resp, got.size()); end
    n_chk++; if (pulses !== 0 || hi_cycles !== 0) begin n_err++; $display("FAIL unknown_btn got pulses=%0d hi=%0d want 0/0", pulses, hi_cycles); end
    n_chk++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL unknown_extra got tx_valid=%b want=0", tx_valid); end
    do_cmd(8'h3F, 8'h00, 0);
    n_chk++; if (got_resp !== exp_resp || pulses !== 0) begin n_err++; $display("FAIL query_resp got=%h want=%h", got_resp, exp_resp); end
    n_chk++; if (first_valid - acc_cyc !== 5) begin n_err++; $display("FAIL query_lat got=%0d want=5", first_valid - acc_cyc); end
    do_cmd(8'h50, 8'h01, 0);
    n_chk++; if (tmo || got_resp !== exp_resp) begin n_err++; $display("FAIL after_unknown got=%h want=%h", got_resp, exp_resp); end
  endtask

  task automatic test_backpressure_reset();
    int n;
    do_cmd(8'h50, 8'h11, 1);
    n_chk++; if (stab_bad !== 0) begin n_err++; $display("FAIL bp_stable got=%0d unstable want=0", stab_bad); end
    n_chk++; if (tmo || got_resp !== exp_resp || got.size() !== 6) begin n_err++; $display("FAIL bp_resp got=%h n=%0d want=%h", got_resp, got.size(), exp_resp); end
    // reset in the middle of SETTLE; the push pulse already reached the calculator
    model_cmd(8'h50, 8'h33);
    tmo = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h50;
    wait_rx_ready(); @(posedge clk); #1;
    rx_data = 8'h33;
    wait_rx_ready(); @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (tx_valid !== 1'b0 || calc_btn !== 4'h0 || rx_ready !== 1'b0) begin n_err++; $display("FAIL settle_reset got v=%b btn=%b rdy=%b want 0/0000/0", tx_valid, calc_btn, rx_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rx_ready !== 1'b1 || tmo) begin n_err++; $display("FAIL settle_reset_release got rdy=%b want=1", rx_ready); end
    // reset while a response is stalled
    model_cmd(8'h50, 8'h22);
    rx_valid = 1'b1; rx_data = 8'h50;
    wait_rx_ready(); @(posedge clk); #1;
    rx_data = 8'h22;
    wait_rx_ready(); @(posedge clk); #1;
    rx_valid = 1'b0;
    n = 0;
    while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++; if (!tx_valid) begin n_err++; $display("FAIL send_reset_wait got tx_valid=0 want=1"); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL send_reset got v=%b d=%h want 0/00", tx_valid, tx_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(8'h3F, 8'h00, 0);
    n_chk++; if (tmo || got_resp !== exp_resp) begin n_err++; $display("FAIL post_reset_query got=%h want=%h", got_resp, exp_resp); end
  endtask

  task automatic test_random();
    logic [7:0] op, arg;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 9));
      arg = 8'($urandom);
      case (k)
        0, 1, 2: op = 8'h50;
        3, 4:    op = 8'h41;
        5, 6:    begin op = 8'h4F; arg = 8'($urandom_range(0, 6)); end
        7:       op = 8'h3F;
        8:       op = 8'h52;
        default: begin
          op = 8'($urandom);
          if (op == 8'h50 || op == 8'h41 || op == 8'h4F || op == 8'h52 || op == 8'h3F) op = 8'h00;
        end
      endcase
      do_cmd(op, arg, int'($urandom_range(0, 2)));
      n_chk++;
      if (tmo || got_resp !== exp_resp || got.size() !== exp_len || pulses !== exp_pulses || stab_bad != 0) begin
        n_err++;
        $display("FAIL random[%0d] op=%h arg=%h got=%h n=%0d p=%0d want=%h n=%0d p=%0d", i, op, arg, got_resp, got.size(), pulses, exp_resp, exp_len, exp_pulses);
      end
    end
    n_chk++; if (btn_bad !== 0) begin n_err++; $display("FAIL btn_discipline got=%0d violations want=0", btn_bad); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_error();
    test_divmod();
    test_append();
    test_unknown();
    test_backpressure_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_cmd_driver.md
# calc_cmd_driver

Byte-stream command front end for the RPN calculator core. It accepts opcode/argument bytes from a serial receiver over a valid/ready interface and replays each command onto the calculator's `sw`/`btn` inputs as exactly one single-cycle button pulse. It then waits out the calculator's worst-case latency, reads back the 32-bit top of stack, error, empty and stack size, and returns them as a 6-byte response over a valid/ready transmit interface. It sits between the UART receiver/transmitter and `calc`, replacing the physical switches and buttons.

## Interface
- `SETTLE_CYCLES`, default 40: idle cycles after a button pulse before readback; must exceed divider latency + 3.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_data` in 8: command byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: driver accepts a byte this cycle.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts `tx_data`.
- `calc_sw` out 8: drives calculator `sw`.
- `calc_btn` out 4: drives calculator `btn`.
- `calc_top` in 16: calculator `out_top`; high half is selected while `btn[0]` is held alone.
- `calc_error` in 1: calculator `out_error`.
- `calc_empty` in 1: calculator `out_empty`.
- `calc_stack_size` in 7: calculator `out_stack_size`.

## Operation
- Command bytes:
  - 0x50 `P` + arg: push; `btn=0010`, `sw=arg`.
  - 0x41 `A` + arg: append; `btn=0100`, `sw=arg`.
  - 0x4F `O` + arg: operation; `btn=1000`, `sw=arg`.
  - 0x52 `R`: calculator reset; `btn=1001`, `sw=0`.
  - 0x3F `?`: query only; no pulse.
  - Any other byte: unknown.
- States:
  - IDLE: `rx_ready=1`. Opcode accepted → GET_ARG for `P`/`A`/`O`; PULSE for `R`; READ_HI for `?`; SEND_ERR for unknown.
  - GET_ARG: `rx_ready=1`. Arg latched into `calc_sw` → PULSE.
  - PULSE: `calc_btn` asserted for exactly one cycle → SETTLE.
  - SETTLE: `btn=0`; counter runs `SETTLE_CYCLES` cycles → READ_HI.
  - READ_HI: `btn=0001`, `sw=0`, 2 cycles; `calc_top` captured into top[31:16] on the second cycle → READ_LO.
  - READ_LO: `btn=0`, 2 cycles; on the second cycle capture top[15:0], error, empty and size → SEND.
  - SEND: 6 bytes, in order: status `{error, empty, 6'b0}`, `{1'b0, size}`, top[31:24], top[23:16], top[15:8], top[7:0] → IDLE after the last handshake.
  - SEND_ERR: 1 byte 0xEE → IDLE.
- `calc_btn` is 0 in every state except PULSE and READ_HI. A button is never asserted on two consecutive PULSE cycles.
- `calc_sw` holds its value through PULSE and SETTLE.
- `rx_ready=0` outside IDLE and GET_ARG. Bytes arriving at other times stay pending upstream.
- Arg bytes are not decoded. Calculator-side errors are reported through the status byte only.

## Timing
- Reset values: `rx_ready=0`, `tx_valid=0`, `tx_data=0`, `calc_btn=0`, `calc_sw=0`, state IDLE, settle counter 0. `rx_ready` rises the first cycle after `rst_n` deasserts.
- Opcode/arg handshake: `rx_valid & rx_ready` at a rising edge.
- PULSE occurs the cycle after the accepting edge.
- First `tx_valid` occurs `SETTLE_CYCLES+5` cycles after the PULSE cycle.
- For `?`: first `tx_valid` occurs 5 cycles after opcode acceptance.
- `tx_data` is stable while `tx_valid & !tx_ready`. The next byte is presented the cycle after a handshake. Back-to-back `tx_ready` gives one byte per cycle.
- Next opcode is accepted no earlier than the cycle after the final tx handshake.
- `rst_n` low in any state: on the next edge, return to IDLE, drop `calc_btn`, `tx_valid` and the partial response. The calculator is not reset.
- Settle counter is `$clog2(SETTLE_CYCLES+1)` bits, loaded on PULSE, decrements to 0.

## Structure
- Package `calc_cmd_pkg`:
  - opcode byte constants (`CMD_PUSH`, `CMD_APPEND`, `CMD_OP`, `CMD_RESET`, `CMD_QUERY`);
  - `RESP_UNKNOWN=8'hEE`;
  - state enum;
  - `RESP_LEN=6`.
- One sub-module: `calc_resp_serializer`, which loads 6 bytes in parallel and emits them over valid/ready, with a `done` pulse. The FSM and settle counter stay in the top level.

## Test plan
- Reset, then `P 12`, `P 34`, `O 00` → last response `00 01 00 00 00 46`. Each response is preceded by exactly one single-cycle `btn` pulse.
- `R`, `O 05` (pop on empty) → status `C0`, size `00`. Top bytes are not checked.
- `P 64`, `P 07`, `O 03` → top `0000000E`. Then `R`, `P 64`, `P 07`, `O 04` → top `00000002`, status `00`.
- `P 12`, `A 34`, `A 56`, `A 78`, `A 9A` → top `3456789A`, size `01`.
- Byte 0x5A → single `EE`. `calc_btn` stays 0 throughout. The next command still works.
- `tx_ready` toggles every 3 cycles during SEND → bytes stay stable, none lost or duplicated. Then `rst_n` low mid-SETTLE → `tx_valid` and `calc_btn` are 0 next cycle, and `rx_ready=1` after release.
